// File: rtl/packet_classifier_pkg.sv
// Shared types and constants for the packet classifier and its output skid buffer.
package packet_classifier_pkg;

    localparam int AST_DWIDTH     = 64;
    localparam int AST_EMPTYWIDTH = 3;
    localparam int HDR_MSB        = 63;
    localparam int HDR_LSB        = 48;
    localparam int HDR_WIDTH      = HDR_MSB - HDR_LSB + 1;

    typedef enum logic {
        IDLE,
        IN_PKT
    } cls_state_t;

    typedef struct packed {
        logic [AST_DWIDTH-1:0]     data;
        logic                      sop;
        logic                      eop;
        logic [AST_EMPTYWIDTH-1:0] empty;
        logic                      channel;
    } ast_beat_t;

    // Bits set in mask are compared; cleared mask bits always match.
    function automatic logic hdr_match(input logic [HDR_WIDTH-1:0] hdr,
                                       input logic [HDR_WIDTH-1:0] value,
                                       input logic [HDR_WIDTH-1:0] mask);
        return ((hdr ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/ast_skid_buffer.sv
// Two-entry register buffer giving a registered sink ready with one cycle of latency.
import packet_classifier_pkg::*;

module ast_skid_buffer #(
    parameter type T = ast_beat_t
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_beat,
    output logic out_valid,
    input  logic out_ready,
    output T     out_beat
);

    T           mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic [1:0] count_n;
    logic       ready_r;
    logic       push;
    logic       pop;

    assign in_ready  = ready_r;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & ready_r;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase
    end

    always_comb begin
        out_beat = '0;
        if (out_valid) out_beat = mem[rd_ptr];
    end

    // Ready is derived from the next occupancy so a third beat can never be accepted.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_r <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count   <= count_n;
            ready_r <= (count_n != 2'd2);
        end
    end

endmodule

// File: rtl/packet_classifier.sv
// Header value/mask match plus length and framing checks; tags every beat with a forward/drop channel.
import packet_classifier_pkg::*;

module packet_classifier #(
    parameter int DWIDTH     = 64,
    parameter int EMPTYWIDTH = 3,
    parameter int MAX_BEATS  = 2048,
    parameter int CNTWIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [DWIDTH-1:0]     ast_data_i,
    input  logic                  ast_valid_i,
    input  logic                  ast_startofpacket_i,
    input  logic                  ast_endofpacket_i,
    input  logic [EMPTYWIDTH-1:0] ast_empty_i,
    output logic                  ast_ready_o,
    input  logic                  ast_ready_i,
    output logic [DWIDTH-1:0]     ast_data_o,
    output logic                  ast_valid_o,
    output logic                  ast_startofpacket_o,
    output logic                  ast_endofpacket_o,
    output logic [EMPTYWIDTH-1:0] ast_empty_o,
    output logic                  ast_channel_o,
    input  logic [15:0]           match_value_i,
    input  logic [15:0]           match_mask_i,
    output logic [CNTWIDTH-1:0]   pkt_cnt_o,
    output logic [CNTWIDTH-1:0]   drop_cnt_o,
    output logic [CNTWIDTH-1:0]   orphan_cnt_o
);

    localparam int             BCW       = $clog2(MAX_BEATS + 2);
    localparam logic [BCW-1:0] BEAT_MAX  = BCW'(MAX_BEATS);
    localparam logic [BCW-1:0] BEAT_SAT  = BCW'(MAX_BEATS + 1);

    function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [BCW-1:0] sat_beat(input logic [BCW-1:0] v);
        return (v == BEAT_SAT) ? v : v + 1'b1;
    endfunction

    cls_state_t     state, state_n;
    logic           hdr_ok, hdr_ok_n;
    logic           bad, bad_n;
    logic [BCW-1:0] beat_cnt, beat_cnt_n;
    logic           orphan;
    logic           in_hs;
    logic           out_hs;
    ast_beat_t      beat_in;
    ast_beat_t      beat_out;

    assign in_hs  = ast_valid_i & ast_ready_o;
    assign out_hs = ast_valid_o & ast_ready_i;

    always_comb begin
        state_n       = state;
        hdr_ok_n      = hdr_ok;
        bad_n         = bad;
        beat_cnt_n    = beat_cnt;
        orphan        = 1'b0;
        beat_in       = '0;
        beat_in.data  = ast_data_i;
        beat_in.eop   = ast_endofpacket_i;
        beat_in.empty = ast_endofpacket_i ? ast_empty_i : '0;
        case (state)
            IDLE: begin
                if (ast_startofpacket_i) begin
                    hdr_ok_n    = hdr_match(ast_data_i[HDR_MSB:HDR_LSB], match_value_i, match_mask_i);
                    beat_cnt_n  = BCW'(1);
                    bad_n       = 1'b0;
                    beat_in.sop = 1'b1;
                    if (!ast_endofpacket_i) state_n = IN_PKT;
                end else begin
                    orphan = 1'b1;
                end
            end
            IN_PKT: begin
                // A stray SOP inside a packet is demoted to a data beat and poisons the packet.
                beat_cnt_n = sat_beat(beat_cnt);
                bad_n      = bad | ast_startofpacket_i | (beat_cnt_n > BEAT_MAX);
                if (ast_endofpacket_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        beat_in.channel = hdr_ok_n & ~bad_n;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= IDLE;
            hdr_ok   <= 1'b0;
            bad      <= 1'b0;
            beat_cnt <= '0;
        end else if (in_hs) begin
            state    <= state_n;
            hdr_ok   <= hdr_ok_n;
            bad      <= bad_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    ast_skid_buffer #(
        .T (ast_beat_t)
    ) u_skid (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .in_valid  (ast_valid_i & ~orphan),
        .in_ready  (ast_ready_o),
        .in_beat   (beat_in),
        .out_valid (ast_valid_o),
        .out_ready (ast_ready_i),
        .out_beat  (beat_out)
    );

    assign ast_data_o          = beat_out.data;
    assign ast_startofpacket_o = beat_out.sop;
    assign ast_endofpacket_o   = beat_out.eop;
    assign ast_empty_o         = beat_out.empty;
    assign ast_channel_o       = beat_out.channel;

    // Statistics follow the output side so they agree with what the resolver sees.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pkt_cnt_o    <= '0;
            drop_cnt_o   <= '0;
            orphan_cnt_o <= '0;
        end else begin
            if (out_hs && beat_out.eop) begin
                pkt_cnt_o <= sat_inc(pkt_cnt_o);
                if (!beat_out.channel) drop_cnt_o <= sat_inc(drop_cnt_o);
            end
            if (in_hs && orphan) orphan_cnt_o <= sat_inc(orphan_cnt_o);
        end
    end

endmodule

// File: tb/tb_packet_classifier.sv
// Directed bench for packet_classifier with MAX_BEATS reduced to 8.
import packet_classifier_pkg::*;

module tb_packet_classifier;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [63:0] ast_data_i;
    logic        ast_valid_i;
    logic        ast_startofpacket_i;
    logic        ast_endofpacket_i;
    logic [2:0]  ast_empty_i;
    logic        ast_ready_o;
    logic        ast_ready_i;
    logic [63:0] ast_data_o;
    logic        ast_valid_o;
    logic        ast_startofpacket_o;
    logic        ast_endofpacket_o;
    logic [2:0]  ast_empty_o;
    logic        ast_channel_o;
    logic [15:0] match_value_i;
    logic [15:0] match_mask_i;
    logic [15:0] pkt_cnt_o;
    logic [15:0] drop_cnt_o;
    logic [15:0] orphan_cnt_o;

    int total = 0;
    int bad   = 0;

    ast_beat_t outq[$];
    int        ready_low_cnt = 0;

    packet_classifier #(
        .DWIDTH(64), .EMPTYWIDTH(3), .MAX_BEATS(8), .CNTWIDTH(16)
    ) dut (
        .clk_i               (clk_i),
        .srst_i              (srst_i),
        .ast_data_i          (ast_data_i),
        .ast_valid_i         (ast_valid_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_empty_i         (ast_empty_i),
        .ast_ready_o         (ast_ready_o),
        .ast_ready_i         (ast_ready_i),
        .ast_data_o          (ast_data_o),
        .ast_valid_o         (ast_valid_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .match_value_i       (match_value_i),
        .match_mask_i        (match_mask_i),
        .pkt_cnt_o           (pkt_cnt_o),
        .drop_cnt_o          (drop_cnt_o),
        .orphan_cnt_o        (orphan_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change just after posedge, so the negedge sees what the next posedge will accept.
    always @(negedge clk_i) begin
        if (!srst_i && ast_valid_o && ast_ready_i)
            outq.push_back('{ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o});
        if (!srst_i && !ast_ready_o) ready_low_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ast_beat_t get_beat(input int idx);
        if (idx < outq.size()) return outq[idx];
        return '0;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic s, input logic e, input logic [2:0] em);
        int guard;
        ast_data_i          = d;
        ast_startofpacket_i = s;
        ast_endofpacket_i   = e;
        ast_empty_i         = em;
        ast_valid_i         = 1'b1;
        guard = 0;
        while (!ast_ready_o && guard < 200) begin
            @(posedge clk_i); #1;
            guard++;
        end
        check("send_handshake", 64'(guard < 200), 64'd1);
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        ast_valid_i         = 1'b0;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i   = 1'b0;
        ast_empty_i         = 3'd0;
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [15:0] hdr, input int i);
        return (i == 0) ? {hdr, 48'h0} : 64'(i);
    endfunction

    task automatic send_pkt(input logic [15:0] hdr, input int n);
        for (int i = 0; i < n; i++)
            send_beat(beat_data(hdr, i), i == 0, i == n - 1, (i == n - 1) ? 3'd5 : 3'd0);
        idle(8);
    endtask

    initial begin
        int        base;
        int        low0;
        int        eop_seen;
        ast_beat_t b;

        srst_i = 1'b1;
        ast_ready_i = 1'b1;
        match_value_i = 16'hABCD;
        match_mask_i  = 16'hFFFF;
        idle(3);

        check("rst_ready_o", 64'(ast_ready_o), 64'd0);
        check("rst_valid_o", 64'(ast_valid_o), 64'd0);
        check("rst_data_o", ast_data_o, 64'd0);
        check("rst_flags_o", 64'({ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}), 64'd0);
        check("rst_cnts", {16'd0, pkt_cnt_o, drop_cnt_o, orphan_cnt_o}, 64'd0);
        srst_i = 1'b0;
        @(posedge clk_i); #1;
        check("ready_after_rst", 64'(ast_ready_o), 64'd1);

        // 4-beat matching packet; non-EOP empty must be forced to 0.
        base = outq.size();
        send_beat(beat_data(16'hABCD, 0), 1'b1, 1'b0, 3'd0);
        send_beat(beat_data(16'hABCD, 1), 1'b0, 1'b0, 3'd3);
        send_beat(beat_data(16'hABCD, 2), 1'b0, 1'b0, 3'd0);
        send_beat(beat_data(16'hABCD, 3), 1'b0, 1'b1, 3'd5);
        idle(8);
        check("t1_nbeats", 64'(outq.size() - base), 64'd4);
        b = get_beat(base + 0); check("t1_b0_sop", 64'(b.sop), 64'd1);
        b = get_beat(base + 1); check("t1_b1_sop", 64'(b.sop), 64'd0);
        check("t1_b1_empty", 64'(b.empty), 64'd0);
        b = get_beat(base + 2); check("t1_b2_data", b.data, 64'd2);
        b = get_beat(base + 3); check("t1_eop", 64'(b.eop), 64'd1);
        check("t1_eop_ch", 64'(b.channel), 64'd1);
        check("t1_eop_empty", 64'(b.empty), 64'd5);
        check("t1_pkt", 64'(pkt_cnt_o), 64'd1);
        check("t1_drop", 64'(drop_cnt_o), 64'd0);

        // Header 0xABCE: mismatch under full mask, match with bits 1:0 masked off.
        base = outq.size();
        send_pkt(16'hABCE, 3);
        check("t2a_nbeats", 64'(outq.size() - base), 64'd3);
        b = get_beat(base + 2); check("t2a_eop_ch", 64'(b.channel), 64'd0);
        check("t2a_drop", 64'(drop_cnt_o), 64'd1);
        check("t2a_pkt", 64'(pkt_cnt_o), 64'd2);
        match_mask_i = 16'hFFFC;
        base = outq.size();
        send_pkt(16'hABCE, 3);
        b = get_beat(base + 2); check("t2b_eop_ch", 64'(b.channel), 64'd1);
        check("t2b_drop", 64'(drop_cnt_o), 64'd1);
        match_mask_i = 16'hFFFF;

        // 10 beats against MAX_BEATS=8: beats 9 and 10 flip to drop.
        base = outq.size();
        send_pkt(16'hABCD, 10);
        check("t3_nbeats", 64'(outq.size() - base), 64'd10);
        for (int i = 0; i < 10; i++) begin
            b = get_beat(base + i);
            check($sformatf("t3_ch%0d", i), 64'(b.channel), 64'(i < 8));
        end
        check("t3_drop", 64'(drop_cnt_o), 64'd2);
        check("t3_pkt", 64'(pkt_cnt_o), 64'd4);

        // Two orphans then a single-beat packet.
        base = outq.size();
        send_beat(64'h1111, 1'b0, 1'b0, 3'd0);
        send_beat(64'h2222, 1'b0, 1'b1, 3'd0);
        send_beat({16'hABCD, 48'h77}, 1'b1, 1'b1, 3'd2);
        idle(8);
        check("t4_nbeats", 64'(outq.size() - base), 64'd1);
        b = get_beat(base);
        check("t4_data", b.data, {16'hABCD, 48'h77});
        check("t4_sop_eop", 64'({b.sop, b.eop}), 64'd3);
        check("t4_ch", 64'(b.channel), 64'd1);
        check("t4_orphan", 64'(orphan_cnt_o), 64'd2);
        check("t4_pkt", 64'(pkt_cnt_o), 64'd5);

        // SOP inside a packet is forwarded without SOP and marks the packet bad.
        base = outq.size();
        send_beat(beat_data(16'hABCD, 0), 1'b1, 1'b0, 3'd0);
        send_beat({16'hABCD, 48'h1}, 1'b1, 1'b0, 3'd0);
        send_beat(64'd2, 1'b0, 1'b1, 3'd0);
        idle(8);
        check("t5_nbeats", 64'(outq.size() - base), 64'd3);
        b = get_beat(base + 0); check("t5_b0_ch", 64'(b.channel), 64'd1);
        b = get_beat(base + 1); check("t5_b1_sop", 64'(b.sop), 64'd0);
        check("t5_b1_ch", 64'(b.channel), 64'd0);
        b = get_beat(base + 2); check("t5_eop_ch", 64'({b.eop, b.channel}), 64'b10);
        check("t5_orphan", 64'(orphan_cnt_o), 64'd2);
        check("t5_drop", 64'(drop_cnt_o), 64'd3);

        // 16 continuous beats with output ready toggling 1,0,0,1.
        base = outq.size();
        low0 = ready_low_cnt;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send_beat(beat_data(16'hABCD, i), i == 0, i == 15, 3'd0);
                ast_valid_i = 1'b0;
                ast_endofpacket_i = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    ast_ready_i = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk_i); #1;
                end
                ast_ready_i = 1'b1;
            end
        join
        idle(8);
        check("t6_nbeats", 64'(outq.size() - base), 64'd16);
        for (int i = 0; i < 16; i++) begin
            b = get_beat(base + i);
            check($sformatf("t6_data%0d", i), b.data, beat_data(16'hABCD, i));
        end
        b = get_beat(base + 15); check("t6_eop_ch", 64'({b.eop, b.channel}), 64'b10);
        check("t6_ready_dropped", 64'(ready_low_cnt > low0), 64'd1);
        check("t6_pkt", 64'(pkt_cnt_o), 64'd7);

        // Reset in the middle of a 6-beat packet.
        base = outq.size();
        send_beat(beat_data(16'hABCD, 0), 1'b1, 1'b0, 3'd0);
        send_beat(64'd1, 1'b0, 1'b0, 3'd0);
        send_beat(64'd2, 1'b0, 1'b0, 3'd0);
        srst_i = 1'b1;
        idle(3);
        check("t7_rst_valid", 64'(ast_valid_o), 64'd0);
        srst_i = 1'b0;
        idle(3);
        eop_seen = 0;
        for (int i = base; i < outq.size(); i++)
            if (outq[i].eop) eop_seen++;
        check("t7_no_eop", 64'(eop_seen), 64'd0);
        check("t7_cnts_zero", {16'd0, pkt_cnt_o, drop_cnt_o, orphan_cnt_o}, 64'd0);
        send_beat(64'd3, 1'b0, 1'b0, 3'd0);
        idle(3);
        check("t7_orphan", 64'(orphan_cnt_o), 64'd1);
        base = outq.size();
        send_pkt(16'hABCD, 2);
        check("t7_nbeats", 64'(outq.size() - base), 64'd2);
        b = get_beat(base + 0); check("t7_sop", 64'(b.sop), 64'd1);
        b = get_beat(base + 1); check("t7_eop_ch", 64'({b.eop, b.channel}), 64'b11);
        check("t7_pkt", 64'(pkt_cnt_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
